// File: rtl/strip_mem_arbiter.sv
// Round-robin read arbiter for the strip drivers sharing one memory.
// Each port reads inside its own PORT_STRIDE region; responses return in grant order.
module strip_mem_arbiter #(
    parameter int NUM_PORTS     = 4,
    parameter int ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH    = 8,
    parameter int PORT_STRIDE   = 600,
    parameter int MEM_LATENCY   = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_PORTS-1:0]               req_valid,
    input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] req_addr,
    output logic [NUM_PORTS-1:0]               req_ready,
    output logic [NUM_PORTS-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]              rsp_data,
    output logic                               rsp_err,
    output logic [ADDRESS_WIDTH-1:0]           mem_addr,
    output logic                               mem_read_enable,
    input  logic [DATA_WIDTH-1:0]              mem_data
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [IDX_W-1:0]         last_grant;
    logic [NUM_PORTS-1:0]     grant;
    logic [IDX_W-1:0]         grant_idx;
    logic [IDX_W-1:0]         cand;
    logic                     grant_any;
    logic [ADDRESS_WIDTH-1:0] offs [NUM_PORTS];
    logic [ADDRESS_WIDTH-1:0] sel_off;
    logic                     in_range;
    logic [ADDRESS_WIDTH-1:0] next_addr;

    // In-flight requests: stage s is visible s+1 cycles after the handshake.
    logic             pipe_valid [MEM_LATENCY+1];
    logic [IDX_W-1:0] pipe_port  [MEM_LATENCY+1];
    logic             pipe_err   [MEM_LATENCY+1];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_offs
        assign offs[g] = req_addr[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    end

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        if (!rst) begin
            for (int k = 1; k <= NUM_PORTS; k++) begin
                cand = IDX_W'((int'(last_grant) + k) % NUM_PORTS);
                if (!grant_any && req_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
            if (grant_any) begin
                grant[grant_idx] = 1'b1;
            end
        end
    end

    assign req_ready = grant;
    assign sel_off   = offs[grant_idx];
    assign in_range  = (32'(sel_off) < 32'(PORT_STRIDE));
    assign next_addr = ADDRESS_WIDTH'(int'(grant_idx) * PORT_STRIDE + int'(sel_off));

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant      <= IDX_W'(NUM_PORTS - 1);
            mem_addr        <= '0;
            mem_read_enable <= 1'b0;
            rsp_valid       <= '0;
            rsp_data        <= '0;
            rsp_err         <= 1'b0;
            for (int s = 0; s <= MEM_LATENCY; s++) begin
                pipe_valid[s] <= 1'b0;
                pipe_port[s]  <= '0;
                pipe_err[s]   <= 1'b0;
            end
        end else begin
            if (grant_any) begin
                last_grant <= grant_idx;
            end
            // Out-of-range requests are granted but never reach the memory.
            mem_read_enable <= grant_any && in_range;
            if (grant_any && in_range) begin
                mem_addr <= next_addr;
            end

            pipe_valid[0] <= grant_any;
            pipe_port[0]  <= grant_idx;
            pipe_err[0]   <= grant_any && !in_range;
            for (int s = 1; s <= MEM_LATENCY; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
                pipe_port[s]  <= pipe_port[s-1];
                pipe_err[s]   <= pipe_err[s-1];
            end

            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            if (pipe_valid[MEM_LATENCY]) begin
                rsp_valid[pipe_port[MEM_LATENCY]] <= 1'b1;
                rsp_err  <= pipe_err[MEM_LATENCY];
                rsp_data <= pipe_err[MEM_LATENCY] ? '0 : mem_data;
            end
        end
    end

endmodule

// File: tb/tb_strip_mem_arbiter.sv
// Directed bench for strip_mem_arbiter: default instance plus a MEM_LATENCY=3 instance
// sharing the same request stimulus, each with its own memory model.
module tb_strip_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [51:0] req_addr  = '0;

    logic [3:0]  req_ready, rsp_valid, req_ready3, rsp_valid3;
    logic [7:0]  rsp_data, rsp_data3, mem_data, mem_data3;
    logic        rsp_err, rsp_err3, mem_read_enable, mem_read_enable3;
    logic [12:0] mem_addr, mem_addr3;
    logic [12:0] a1;
    logic [12:0] a3 [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    strip_mem_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_read_enable(mem_read_enable),
        .mem_data(mem_data)
    );

    strip_mem_arbiter #(.MEM_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready3), .rsp_valid(rsp_valid3), .rsp_data(rsp_data3),
        .rsp_err(rsp_err3), .mem_addr(mem_addr3), .mem_read_enable(mem_read_enable3),
        .mem_data(mem_data3)
    );

    // Memory contents: low address byte XOR 0x5A. Data appears MEM_LATENCY cycles after the address.
    function automatic logic [7:0] mem_f(input logic [12:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        if (mem_read_enable)  a1 <= mem_addr;
        else                  a1 <= 'x;
        if (mem_read_enable3) a3[0] <= mem_addr3;
        else                  a3[0] <= 'x;
        a3[1] <= a3[0];
        a3[2] <= a3[1];
    end
    assign mem_data  = mem_f(a1);
    assign mem_data3 = mem_f(a3[2]);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [3:0] v, input int o0, input int o1, input int o2, input int o3);
        req_valid = v;
        req_addr  = {13'(o3), 13'(o2), 13'(o1), 13'(o0)};
    endtask

    logic [3:0]  exp_g  [5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [12:0] exp_a  [5]  = '{13'd10, 13'd620, 13'd1230, 13'd1840, 13'd10};
    logic [3:0]  exp_r  [10] = '{0, 0, 0, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 0, 0};
    logic [7:0]  exp_d  [10] = '{0, 0, 0, 8'h50, 8'h36, 8'h94, 8'h6A, 8'h50, 0, 0};
    logic [3:0]  exp_r3 [10] = '{0, 0, 0, 0, 0, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0]  exp_d3 [10] = '{0, 0, 0, 0, 0, 8'h50, 8'h36, 8'h94, 8'h6A, 8'h50};
    logic [3:0]  exp_f  [4]  = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};

    initial begin
        // Reset state, with every port requesting.
        rst = 1'b1;
        set_req(4'b1111, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk); #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_re", 32'(mem_read_enable), 0);

        // Single request from port 2, granted in the first cycle out of reset.
        @(negedge clk);
        rst = 1'b0;
        set_req(4'b0100, 0, 0, 5, 0); #1;
        chk("single_grant", 32'(req_ready), 32'b0100);
        chk("single_grant3", 32'(req_ready3), 32'b0100);
        @(negedge clk);
        set_req(4'b0000, 0, 0, 0, 0); #1;
        chk("single_mem_addr", 32'(mem_addr), 1205);
        chk("single_mem_re", 32'(mem_read_enable), 1);
        chk("single_no_rsp_t1", 32'(rsp_valid), 0);
        @(negedge clk); #1;
        chk("single_mem_re_off", 32'(mem_read_enable), 0);
        chk("single_no_rsp_t2", 32'(rsp_valid), 0);
        @(negedge clk); #1;
        chk("single_rsp_valid", 32'(rsp_valid), 32'b0100);
        chk("single_rsp_data", 32'(rsp_data), 32'hEF);
        chk("single_rsp_err", 32'(rsp_err), 0);
        chk("single_rsp3_early", 32'(rsp_valid3), 0);
        @(negedge clk); #1;
        chk("single_rsp_pulse", 32'(rsp_valid), 0);
        chk("single_mem_addr_hold", 32'(mem_addr), 1205);
        @(negedge clk); #1;
        chk("single_rsp3_valid", 32'(rsp_valid3), 32'b0100);
        chk("single_rsp3_data", 32'(rsp_data3), 32'hEF);
        @(negedge clk); #1;
        chk("single_rsp3_pulse", 32'(rsp_valid3), 0);

        // All four ports request continuously right after reset.
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            rst = 1'b0;
            if (k < 5) set_req(4'b1111, 10, 20, 30, 40);
            else       set_req(4'b0000, 0, 0, 0, 0);
            #1;
            if (k < 5) chk($sformatf("all_grant_%0d", k), 32'(req_ready), 32'(exp_g[k]));
            else       chk($sformatf("all_idle_%0d", k), 32'(req_ready), 0);
            if (k >= 1 && k <= 5) begin
                chk($sformatf("all_mem_addr_%0d", k), 32'(mem_addr), 32'(exp_a[k-1]));
                chk($sformatf("all_mem_re_%0d", k), 32'(mem_read_enable), 1);
            end
            chk($sformatf("all_rsp_%0d", k), 32'(rsp_valid), 32'(exp_r[k]));
            if (exp_r[k] != 0) chk($sformatf("all_data_%0d", k), 32'(rsp_data), 32'(exp_d[k]));
            chk($sformatf("all_rsp3_%0d", k), 32'(rsp_valid3), 32'(exp_r3[k]));
            if (exp_r3[k] != 0) chk($sformatf("all_data3_%0d", k), 32'(rsp_data3), 32'(exp_d3[k]));
        end

        // Ports 1 and 3 compete continuously.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            set_req(4'b1010, 0, 7, 0, 9); #1;
            chk($sformatf("fair_grant_%0d", k), 32'(req_ready), 32'(exp_f[k]));
        end
        @(negedge clk);
        set_req(4'b0000, 0, 0, 0, 0);
        repeat (6) @(negedge clk);

        // Out-of-range offset on port 0, then the last in-range offset on port 3.
        set_req(4'b0001, 600, 0, 0, 0); #1;
        chk("oor_grant", 32'(req_ready), 32'b0001);
        @(negedge clk);
        set_req(4'b1000, 0, 0, 0, 599); #1;
        chk("edge_grant", 32'(req_ready), 32'b1000);
        chk("oor_mem_re", 32'(mem_read_enable), 0);
        chk("oor_mem_addr_hold", 32'(mem_addr), 1809);
        @(negedge clk);
        set_req(4'b0000, 0, 0, 0, 0); #1;
        chk("edge_mem_re", 32'(mem_read_enable), 1);
        chk("edge_mem_addr", 32'(mem_addr), 2399);
        @(negedge clk); #1;
        chk("oor_rsp_valid", 32'(rsp_valid), 32'b0001);
        chk("oor_rsp_err", 32'(rsp_err), 1);
        chk("oor_rsp_data", 32'(rsp_data), 0);
        @(negedge clk); #1;
        chk("edge_rsp_valid", 32'(rsp_valid), 32'b1000);
        chk("edge_rsp_err", 32'(rsp_err), 0);
        chk("edge_rsp_data", 32'(rsp_data), 32'h05);
        @(negedge clk); #1;
        chk("oor_idle_err", 32'(rsp_err), 0);
        chk("oor_rsp3_valid", 32'(rsp_valid3), 32'b0001);
        chk("oor_rsp3_err", 32'(rsp_err3), 1);
        chk("oor_rsp3_data", 32'(rsp_data3), 0);
        @(negedge clk); #1;
        chk("edge_rsp3_valid", 32'(rsp_valid3), 32'b1000);
        chk("edge_rsp3_data", 32'(rsp_data3), 32'h05);
        repeat (2) @(negedge clk);

        // Reset one cycle after a grant discards the request and restores port 0 priority.
        set_req(4'b0010, 0, 3, 0, 0); #1;
        chk("mid_grant", 32'(req_ready), 32'b0010);
        @(negedge clk);
        rst = 1'b1;
        set_req(4'b0000, 0, 0, 0, 0); #1;
        chk("mid_rst_ready", 32'(req_ready), 0);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            rst = 1'b0; #1;
            chk($sformatf("mid_no_rsp_%0d", j), 32'(rsp_valid), 0);
            chk($sformatf("mid_no_rsp3_%0d", j), 32'(rsp_valid3), 0);
        end
        chk("mid_mem_addr_cleared", 32'(mem_addr), 0);
        @(negedge clk);
        set_req(4'b1001, 1, 0, 0, 1); #1;
        chk("mid_next_grant", 32'(req_ready), 32'b0001);
        @(negedge clk);
        set_req(4'b0000, 0, 0, 0, 0);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
